// File: rtl/alu_issue_stage.sv
// alu_issue_stage: request FIFO feeding a combinational ALU, plus a
// valid/ready response register that captures the ALU result.
// The head of the FIFO drives the ALU inputs directly (zeros when empty).
// Optional macro ALU_ISSUE_STATS_EN adds saturating op_count/ovf_count.
module alu_issue_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    input  logic [2:0]               req_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [2:0]               alu_opcode,
    input  logic                     alu_out,
    input  logic                     alu_out_c,
    input  logic [WIDTH-1:0]         alu_out_s,
    input  logic                     alu_overflow,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2:0]               rsp_op,
    output logic                     rsp_out,
    output logic                     rsp_out_c,
    output logic [WIDTH-1:0]         rsp_out_s,
    output logic                     rsp_overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [7:0]               op_count,
    output logic [7:0]               ovf_count
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [2:0]       r_mem_op [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_rsp_valid;
    logic [2:0]       r_rsp_op;
    logic             r_rsp_out;
    logic             r_rsp_out_c;
    logic [WIDTH-1:0] r_rsp_out_s;
    logic             r_rsp_overflow;

    logic             w_empty;
    logic             w_req_ready;
    logic             w_push;
    logic             w_pop;

    // Handshake decode: push when not full, pop when head present and response slot free
    always_comb begin
        w_empty     = (r_count == CW'(0));
        w_req_ready = (r_count != CW'(DEPTH));
        w_push      = req_valid && w_req_ready;
        w_pop       = !w_empty && (!r_rsp_valid || rsp_ready);
    end

    // FIFO storage; no reset needed because empty entries are never observed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= req_a;
            r_mem_b[r_wr_ptr]  <= req_b;
            r_mem_op[r_wr_ptr] <= req_op;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    // Response register: capture ALU result on pop, drop valid when drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_op       <= '0;
            r_rsp_out      <= 1'b0;
            r_rsp_out_c    <= 1'b0;
            r_rsp_out_s    <= '0;
            r_rsp_overflow <= 1'b0;
        end else if (w_pop) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_op       <= r_mem_op[r_rd_ptr];
            r_rsp_out      <= alu_out;
            r_rsp_out_c    <= alu_out_c;
            r_rsp_out_s    <= alu_out_s;
            r_rsp_overflow <= alu_overflow;
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid    <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    logic [7:0] r_op_count;
    logic [7:0] r_ovf_count;

    // Saturating statistics counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count  <= '0;
            r_ovf_count <= '0;
        end else if (w_pop) begin
            if (r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
            if (alu_overflow && (r_ovf_count != 8'hFF)) r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign op_count  = r_op_count;
    assign ovf_count = r_ovf_count;
`endif

    // Head is presented to the ALU without a register stage
    assign alu_a        = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign alu_b        = w_empty ? '0 : r_mem_b[r_rd_ptr];
    assign alu_opcode   = w_empty ? 3'b000 : r_mem_op[r_rd_ptr];

    assign req_ready    = w_req_ready;
    assign fifo_count   = r_count;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_op       = r_rsp_op;
    assign rsp_out      = r_rsp_out;
    assign rsp_out_c    = r_rsp_out_c;
    assign rsp_out_s    = r_rsp_out_s;
    assign rsp_overflow = r_rsp_overflow;

endmodule
